// File: rtl/loader_pkg.sv
// Shared constants for the instruction memory loader: geometry and FSM state encoding.
package loader_pkg;

   localparam int unsigned ADDR_WIDTH     = 11;
   localparam int unsigned DATA_WIDTH     = 32;
   localparam int unsigned DEPTH          = 2048;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned IDX_WIDTH      = $clog2(BYTES_PER_WORD);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StCntHi = 3'd1;
   localparam logic [2:0] StCntLo = 3'd2;
   localparam logic [2:0] StLoad  = 3'd3;
   localparam logic [2:0] StCheck = 3'd4;
   localparam logic [2:0] StDone  = 3'd5;
   localparam logic [2:0] StError = 3'd6;

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream MSB-first into 32-bit words and keeps a running 8-bit sum of the bytes.
module word_assembler
   import loader_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  valid_i,
   input  logic [7:0]            byte_i,
   output logic                  word_ready_o,
   output logic [DATA_WIDTH-1:0] word_o,
   output logic [7:0]            sum_o
);

   logic [DATA_WIDTH-9:0] shift_q, shift_d;
   logic [IDX_WIDTH-1:0]  idx_q, idx_d;
   logic [7:0]            sum_q, sum_d;

   always_comb begin
      shift_d = shift_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      if (clear_i) begin
         shift_d = '0;
         idx_d   = '0;
         sum_d   = '0;
      end else if (valid_i) begin
         shift_d = {shift_q[DATA_WIDTH-17:0], byte_i};
         idx_d   = idx_q + 1'b1;
         sum_d   = sum_q + byte_i;
      end
   end

   // The completed word bypasses the shift register so a byte can arrive every cycle.
   assign word_ready_o = valid_i && !clear_i && (idx_q == IDX_WIDTH'(BYTES_PER_WORD - 1));
   assign word_o       = {shift_q, byte_i};
   assign sum_o        = sum_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         shift_q <= '0;
         idx_q   <= '0;
         sum_q   <= '0;
      end else begin
         shift_q <= shift_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
      end
   end

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a counted, checksummed byte stream into instruction memory while holding the CPU.
module inst_mem_loader #(
   parameter int unsigned ADDR_WIDTH = 11,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 2048
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   import loader_pkg::StIdle;
   import loader_pkg::StCntHi;
   import loader_pkg::StCntLo;
   import loader_pkg::StLoad;
   import loader_pkg::StCheck;
   import loader_pkg::StDone;
   import loader_pkg::StError;

   logic [2:0]            state_q, state_d;
   logic [15:0]           count_q, count_d;
   logic [ADDR_WIDTH:0]   words_q, words_d;
   logic [ADDR_WIDTH:0]   words_inc;
   logic [15:0]           count_full;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic                  idle_like;
   logic                  clear;
   logic                  asm_valid;
   logic                  word_ready;
   logic [DATA_WIDTH-1:0] word;
   logic [7:0]            sum;

   assign idle_like  = (state_q == StIdle) || (state_q == StDone) || (state_q == StError);
   assign clear      = idle_like && start;
   assign asm_valid  = rx_valid && (state_q == StLoad);
   assign words_inc  = words_q + 1'b1;
   assign count_full = {count_q[15:8], rx_data};

   word_assembler u_word_assembler (
      .clk_i        (clock),
      .rst_ni       (reset),
      .clear_i      (clear),
      .valid_i      (asm_valid),
      .byte_i       (rx_data),
      .word_ready_o (word_ready),
      .word_o       (word),
      .sum_o        (sum)
   );

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      words_d  = words_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      mem_we_d = 1'b0;
      case (state_q)
         StIdle, StDone, StError: begin
            if (start) begin
               state_d = StCntHi;
               count_d = '0;
               words_d = '0;
               addr_d  = '0;
            end
         end
         StCntHi: begin
            if (rx_valid) begin
               count_d[15:8] = rx_data;
               state_d       = StCntLo;
            end
         end
         StCntLo: begin
            if (rx_valid) begin
               count_d = count_full;
               if (count_full == 16'd0) begin
                  state_d = StCheck;
               end else if (count_full > 16'(DEPTH)) begin
                  state_d = StError;
               end else begin
                  state_d = StLoad;
               end
            end
         end
         StLoad: begin
            if (word_ready) begin
               mem_we_d = 1'b1;
               addr_d   = words_q[ADDR_WIDTH-1:0];
               wdata_d  = word;
               words_d  = words_inc;
               if (32'(words_inc) == 32'(count_q)) begin
                  state_d = StCheck;
               end
            end
         end
         StCheck: begin
            if (rx_valid) begin
               state_d = (rx_data == sum) ? StDone : StError;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= StIdle;
         count_q  <= '0;
         words_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         mem_we_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         words_q  <= words_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         mem_we_q <= mem_we_d;
      end
   end

   assign busy         = (state_q == StCntHi) || (state_q == StCntLo) ||
                         (state_q == StLoad)  || (state_q == StCheck);
   assign done         = (state_q == StDone);
   assign error        = (state_q == StError);
   // A rejected image keeps the CPU frozen until a good load completes.
   assign cpu_hold     = busy || error;
   assign mem_we       = mem_we_q;
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench: directed sessions with random payloads against a byte-list reference model.
module tb_inst_mem_loader;

   localparam int unsigned AW = 11;
   localparam int unsigned DW = 32;

   logic          clock    = 1'b0;
   logic          reset    = 1'b0;
   logic          start    = 1'b0;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data  = 8'h00;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          cpu_hold, busy, done, error;
   logic [AW:0]   words_loaded;

   int total    = 0;
   int bad      = 0;
   int we_count = 0;
   logic [7:0] pay [0:8191];

   inst_mem_loader #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .DEPTH      (2048)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .cpu_hold     (cpu_hold),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (mem_we === 1'b1) we_count++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
   endtask

   task automatic gap();
      rx_valid = 1'b0;
      tick();
   endtask

   task automatic fill_random(input int nbytes);
      for (int i = 0; i < nbytes; i++) pay[i] = 8'($urandom_range(0, 255));
   endtask

   // One full session; expected writes, sum and verdict come from the byte list in pay[].
   task automatic run_session(input int n, input bit b2b, input bit use_cs,
                              input logic [7:0] cs_in, input bit stray);
      int          w0;
      logic [15:0] cnt;
      logic [7:0]  model_sum;
      logic [7:0]  cs;
      logic [31:0] word;
      bit          ok;
      w0  = we_count;
      cnt = 16'(n);
      rx_valid = 1'b0;
      start    = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy", busy, 1);
      check("start_hold", cpu_hold, 1);
      check("start_done", done, 0);
      check("start_error", error, 0);
      check("start_words", words_loaded, 0);
      send_byte(cnt[15:8]);
      if (!b2b) gap();
      send_byte(cnt[7:0]);
      if (n > 2048) begin
         rx_valid = 1'b0;
         check("over_error", error, 1);
         check("over_busy", busy, 0);
         check("over_hold", cpu_hold, 1);
         check("over_writes", we_count - w0, 0);
         return;
      end
      model_sum = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
         if (!b2b && $urandom_range(0, 2) == 0) gap();
         if (stray && i == 5) begin
            rx_valid = 1'b0;
            start    = 1'b1;
            tick();
            start = 1'b0;
            check("stray_start_busy", busy, 1);
         end
         send_byte(pay[i]);
         model_sum = model_sum + pay[i];
         if (i % 4 == 3) begin
            word = {pay[i-3], pay[i-2], pay[i-1], pay[i]};
            check("we", mem_we, 1);
            check("addr", mem_addr, 32'(i / 4));
            check("wdata", mem_wdata, word);
            check("words", words_loaded, 32'(i / 4 + 1));
         end
      end
      cs = use_cs ? cs_in : model_sum;
      ok = (cs == model_sum);
      if (!b2b) gap();
      send_byte(cs);
      rx_valid = 1'b0;
      check("end_done", done, 32'(ok));
      check("end_error", error, 32'(!ok));
      check("end_busy", busy, 0);
      check("end_hold", cpu_hold, 32'(!ok));
      check("end_words", words_loaded, 32'(n));
      check("end_writes", we_count - w0, 32'(n));
   endtask

   initial begin
      int w0;
      reset = 1'b0;
      tick();
      tick();
      check("rst_we", mem_we, 0);
      check("rst_busy", busy, 0);
      check("rst_hold", cpu_hold, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_words", words_loaded, 0);
      reset = 1'b1;
      tick();

      // Stray bytes in IDLE must not start anything.
      send_byte(8'h00);
      send_byte(8'h02);
      gap();
      check("idle_stray_busy", busy, 0);
      check("idle_stray_writes", we_count, 0);

      // Directed image: the matching checksum is the model's sum, a wrong one errors.
      pay[0] = 8'h00; pay[1] = 8'h22; pay[2] = 8'h60; pay[3] = 8'h22;
      pay[4] = 8'h00; pay[5] = 8'h45; pay[6] = 8'h60; pay[7] = 8'h24;
      run_session(2, 1'b0, 1'b0, 8'h00, 1'b0);
      run_session(2, 1'b0, 1'b1, 8'h00, 1'b0);

      // Back-to-back bytes, random payloads.
      for (int k = 0; k < 3; k++) begin
         int n;
         n = int'($urandom_range(1, 6));
         fill_random(4 * n);
         run_session(n, 1'b1, 1'b0, 8'h00, 1'b0);
      end

      // Zero count.
      run_session(0, 1'b0, 1'b1, 8'h00, 1'b0);

      // Oversize count, then recovery.
      run_session(2049, 1'b0, 1'b0, 8'h00, 1'b0);
      fill_random(12);
      run_session(3, 1'b0, 1'b0, 8'h00, 1'b0);

      // Largest accepted image, last address 2047.
      fill_random(8192);
      run_session(2048, 1'b1, 1'b0, 8'h00, 1'b0);

      // Reset in the middle of a load.
      fill_random(12);
      start = 1'b1;
      tick();
      start = 1'b0;
      send_byte(8'h00);
      send_byte(8'h03);
      for (int i = 0; i < 6; i++) send_byte(pay[i]);
      rx_valid = 1'b0;
      check("midload_words", words_loaded, 1);
      reset = 1'b0;
      tick();
      check("mrst_we", mem_we, 0);
      check("mrst_busy", busy, 0);
      check("mrst_hold", cpu_hold, 0);
      check("mrst_done", done, 0);
      check("mrst_error", error, 0);
      check("mrst_addr", mem_addr, 0);
      check("mrst_wdata", mem_wdata, 0);
      check("mrst_words", words_loaded, 0);
      reset = 1'b1;
      tick();
      fill_random(12);
      run_session(3, 1'b0, 1'b0, 8'h00, 1'b0);

      // Start pulse during LOAD is ignored, then stray bytes after DONE are ignored.
      fill_random(16);
      run_session(4, 1'b0, 1'b0, 8'h00, 1'b1);
      w0 = we_count;
      send_byte(8'hA5);
      send_byte(8'h5A);
      gap();
      check("done_stray_done", done, 1);
      check("done_stray_words", words_loaded, 4);
      check("done_stray_writes", we_count - w0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
